if_fetch_unit: RTL and testbench

Instruction-fetch front end for the 3-stage RV32 pipeline. It owns the fetch PC, issues in-order read requests to instruction memory over a valid/ready channel, and holds returned words with their PCs in a small queue. It presents {pc, instr} pairs to decode with a valid/ready handshake, and squashes in-flight fetches on a redirect from execute (branch/jump).

---
 rtl/if_pkg.sv | 17 +
 rtl/fetch_queue.sv | 60 ++++++
 rtl/if_fetch_unit.sv | 77 +++++++
 tb/tb_if_fetch_unit.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// if_pkg: shared types and helpers for the instruction-fetch front end
package if_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic            filled;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
        return pc + XLEN'(4);
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: circular buffer of fetched {pc, instr} pairs with separate alloc/fill/free pointers
module fetch_queue
    import if_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            alloc,
    input  logic [XLEN-1:0] alloc_pc,
    input  logic            fill,
    input  logic [31:0]     fill_instr,
    input  logic            free,
    output logic            head_valid,
    output fetch_entry_t    head,
    output logic [CW-1:0]   count,
    output logic [CW-1:0]   pending
);

    fetch_entry_t    q [DEPTH];
    logic [AW-1:0]   alloc_ptr;
    logic [AW-1:0]   fill_ptr;
    logic [AW-1:0]   free_ptr;
    logic            do_fill;
    logic            do_free;

    assign head       = q[free_ptr];
    assign head_valid = count != '0 && head.filled;
    assign do_fill    = fill && pending != '0;
    assign do_free    = free && head_valid;

    // Pointer and occupancy bookkeeping; alloc/fill/free never target the same slot in one cycle
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            free_ptr  <= '0;
            count     <= '0;
            pending   <= '0;
            for (int i = 0; i < DEPTH; i++) q[i].filled <= 1'b0;
        end else begin
            if (alloc) begin
                q[alloc_ptr] <= '{pc: alloc_pc, instr: 32'h0, filled: 1'b0};
                alloc_ptr    <= alloc_ptr + 1'b1;
            end
            if (do_fill) begin
                q[fill_ptr].instr  <= fill_instr;
                q[fill_ptr].filled <= 1'b1;
                fill_ptr           <= fill_ptr + 1'b1;
            end
            if (do_free) free_ptr <= free_ptr + 1'b1;
            count   <= count + CW'(alloc) - CW'(do_free);
            pending <= pending + CW'(alloc) - CW'(do_fill);
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: fetch PC, credit-limited imem requests and redirect squashing
module if_fetch_unit
    import if_pkg::*;
#(
    parameter int XLEN = if_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = if_pkg::RESET_PC,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            dec_valid,
    input  logic            dec_ready,
    output logic [XLEN-1:0] dec_pc,
    output logic [31:0]     dec_instr
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0] fetch_pc;
    logic [CW-1:0]   drop_cnt;
    logic [CW-1:0]   count;
    logic [CW-1:0]   pending;
    logic [CW:0]     in_flight;
    logic            req_fire;
    logic            rsp_fill;
    logic            unused_lo;
    fetch_entry_t    head;

    assign unused_lo      = ^redirect_pc[1:0];
    assign imem_req_valid = !rst && ({1'b0, count} + {1'b0, drop_cnt} < (CW+1)'(DEPTH));
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign rsp_fill       = imem_rsp_valid && drop_cnt == '0 && !redirect_valid;
    assign in_flight      = {1'b0, pending} + {1'b0, drop_cnt};
    assign dec_pc         = head.pc;
    assign dec_instr      = head.instr;

    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect_valid),
        .alloc      (req_fire && !redirect_valid),
        .alloc_pc   (fetch_pc),
        .fill       (rsp_fill),
        .fill_instr (imem_rsp_data),
        .free       (dec_ready),
        .head_valid (dec_valid),
        .head       (head),
        .count      (count),
        .pending    (pending)
    );

    // Fetch PC and stale-response counter; a redirect converts everything in flight into drops
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            drop_cnt <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
            drop_cnt <= CW'(in_flight + (CW+1)'(req_fire) - (CW+1)'(imem_rsp_valid && in_flight != '0));
        end else begin
            if (req_fire) fetch_pc <= next_pc(fetch_pc);
            if (imem_rsp_valid && drop_cnt != '0) drop_cnt <= drop_cnt - 1'b1;
        end
    end

    // A response must always have an accepted, unanswered request behind it
    assert property (@(posedge clk) disable iff (rst) imem_rsp_valid |-> (drop_cnt != '0 || pending != '0));

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: randomized memory model plus program-order scoreboard for if_fetch_unit
module tb_if_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int DEPTH = 2;

    typedef struct {
        int          kind;
        logic [31:0] pc;
        logic [31:0] instr;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        dec_valid;
    logic        dec_ready = 1'b1;
    logic [31:0] dec_pc;
    logic [31:0] dec_instr;

    int          checks = 0;
    int          failures = 0;
    int          rdy_pct = 100;
    int          rsp_pct = 100;
    ev_t         log_q[$];
    ev_t         obs_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] mq[$];

    if_fetch_unit #(.XLEN(32), .RESET_PC(RST_PC), .DEPTH(DEPTH)) u_dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_pc         (dec_pc),
        .dec_instr      (dec_instr)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] img(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    // Expected PCs per event kind: program order restarting at reset or redirect target
    function automatic void build_exp(input int k);
        logic [31:0] e;
        e = RST_PC;
        exp_q.delete();
        foreach (log_q[i]) begin
            if (log_q[i].kind == 3 || log_q[i].kind == 2) e = log_q[i].pc;
            else if (log_q[i].kind == k) begin
                exp_q.push_back(e);
                e = e + 32'd4;
            end
        end
    endfunction

    function automatic void get_obs(input int k);
        obs_q.delete();
        foreach (log_q[i]) if (log_q[i].kind == k) obs_q.push_back(log_q[i]);
    endfunction

    // Memory: record accepted requests; memory is reset together with the DUT
    always @(posedge clk) begin
        if (rst) mq.delete();
        else if (imem_req_valid && imem_req_ready) mq.push_back(imem_req_addr);
    end

    // Memory: random ready and in-order responses at least one cycle after acceptance
    always @(negedge clk) begin
        imem_req_ready = int'($urandom_range(99)) < rdy_pct;
        if (!rst && mq.size() > 0 && int'($urandom_range(99)) < rsp_pct) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = img(mq.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
    end

    // Event log: 0=request, 1=decode, 2=redirect, 3=reset
    always @(posedge clk) begin
        if (rst) log_q.push_back('{kind: 3, pc: RST_PC, instr: 32'h0});
        else begin
            if (imem_req_valid && imem_req_ready) log_q.push_back('{kind: 0, pc: imem_req_addr, instr: 32'h0});
            if (redirect_valid) log_q.push_back('{kind: 2, pc: {redirect_pc[31:2], 2'b00}, instr: 32'h0});
            else if (dec_valid && dec_ready) log_q.push_back('{kind: 1, pc: dec_pc, instr: dec_instr});
        end
    end

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        redirect_valid = 1'b0;
        repeat (2) @(negedge clk);
        log_q.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        dec_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL reset_req_valid got=%b want=0", imem_req_valid); end
        checks++;
        if (dec_valid !== 1'b0) begin failures++; $display("FAIL reset_dec_valid got=%b want=0", dec_valid); end
        checks++;
        if (u_dut.drop_cnt !== 2'd0) begin failures++; $display("FAIL reset_drop_cnt got=%0d want=0", u_dut.drop_cnt); end
        rst = 1'b0;
        #1;
        checks++;
        if (imem_req_valid !== 1'b1) begin failures++; $display("FAIL release_req_valid got=%b want=1", imem_req_valid); end
        checks++;
        if (imem_req_addr !== RST_PC) begin failures++; $display("FAIL release_req_addr got=%h want=%h", imem_req_addr, RST_PC); end
    endtask

    task automatic test_stream();
        rdy_pct = 100; rsp_pct = 100; dec_ready = 1'b1;
        reset_dut();
        repeat (30) @(negedge clk);
        get_obs(1); build_exp(1);
        checks++;
        if (obs_q.size() < 15) begin failures++; $display("FAIL stream_count got=%0d want>=15", obs_q.size()); end
        foreach (obs_q[i]) begin
            checks++;
            if (obs_q[i].pc !== exp_q[i] || obs_q[i].instr !== img(exp_q[i])) begin
                failures++;
                $display("FAIL stream_dec[%0d] got=%h/%h want=%h/%h", i, obs_q[i].pc, obs_q[i].instr, exp_q[i], img(exp_q[i]));
            end
        end
        get_obs(0); build_exp(0);
        foreach (obs_q[i]) begin
            checks++;
            if (obs_q[i].pc !== exp_q[i]) begin failures++; $display("FAIL stream_req[%0d] got=%h want=%h", i, obs_q[i].pc, exp_q[i]); end
        end
    endtask

    task automatic test_stall();
        int n;
        rdy_pct = 100; rsp_pct = 100; dec_ready = 1'b0;
        reset_dut();
        repeat (6) @(negedge clk);
        #1;
        get_obs(0);
        checks++;
        if (obs_q.size() != DEPTH) begin failures++; $display("FAIL stall_req_count got=%0d want=%0d", obs_q.size(), DEPTH); end
        checks++;
        if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL stall_req_valid got=%b want=0", imem_req_valid); end
        dec_ready = 1'b1;
        repeat (20) @(negedge clk);
        get_obs(1); build_exp(1);
        n = obs_q.size();
        checks++;
        if (n < 8) begin failures++; $display("FAIL stall_dec_count got=%0d want>=8", n); end
        foreach (obs_q[i]) begin
            checks++;
            if (obs_q[i].pc !== exp_q[i] || obs_q[i].instr !== img(exp_q[i])) begin
                failures++;
                $display("FAIL stall_dec[%0d] got=%h/%h want=%h/%h", i, obs_q[i].pc, obs_q[i].instr, exp_q[i], img(exp_q[i]));
            end
        end
    endtask

    task automatic test_redirect();
        rdy_pct = 100; rsp_pct = 0; dec_ready = 1'b1;
        reset_dut();
        for (int i = 0; i < 10 && mq.size() < 2; i++) @(negedge clk);
        checks++;
        if (mq.size() != 2) begin failures++; $display("FAIL redir_outstanding got=%0d want=2", mq.size()); end
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0100;
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        checks++;
        if (u_dut.drop_cnt !== 2'(mq.size())) begin failures++; $display("FAIL redir_drop_cnt got=%0d want=%0d", u_dut.drop_cnt, mq.size()); end
        checks++;
        if (imem_req_valid !== 1'b0 || imem_req_addr !== 32'h100) begin
            failures++; $display("FAIL redir_req got=%b/%h want=0/00000100", imem_req_valid, imem_req_addr);
        end
        rsp_pct = 100;
        repeat (15) @(negedge clk);
        checks++;
        if (u_dut.drop_cnt !== 2'd0) begin failures++; $display("FAIL redir_drop_done got=%0d want=0", u_dut.drop_cnt); end
        get_obs(1); build_exp(1);
        checks++;
        if (obs_q.size() < 3 || obs_q[0].pc !== 32'h100) begin
            failures++; $display("FAIL redir_first_dec count=%0d want>=3 starting at 00000100", obs_q.size());
        end
        foreach (obs_q[i]) begin
            checks++;
            if (obs_q[i].pc !== exp_q[i] || obs_q[i].instr !== img(exp_q[i])) begin
                failures++;
                $display("FAIL redir_dec[%0d] got=%h/%h want=%h/%h", i, obs_q[i].pc, obs_q[i].instr, exp_q[i], img(exp_q[i]));
            end
        end
    endtask

    task automatic test_same_cycle();
        bit hit;
        hit = 1'b0;
        rdy_pct = 100; rsp_pct = 100; dec_ready = 1'b1;
        reset_dut();
        for (int i = 0; i < 20 && !hit; i++) begin
            @(negedge clk);
            #1;
            hit = imem_req_valid && imem_req_ready && imem_rsp_valid;
        end
        checks++;
        if (!hit) begin failures++; $display("FAIL same_cycle_setup got=0 want=1"); end
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0200;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        checks++;
        if (u_dut.drop_cnt !== 2'(mq.size()) || mq.size() == 0) begin
            failures++; $display("FAIL same_cycle_drop_cnt got=%0d want=%0d (nonzero)", u_dut.drop_cnt, mq.size());
        end
        repeat (15) @(negedge clk);
        get_obs(1); build_exp(1);
        foreach (log_q[i]) if (log_q[i].kind == 2) begin
            for (int j = i + 1; j < log_q.size(); j++) if (log_q[j].kind == 1) begin
                checks++;
                if (log_q[j].pc !== 32'h200) begin failures++; $display("FAIL same_cycle_first_dec got=%h want=00000200", log_q[j].pc); end
                break;
            end
        end
        foreach (obs_q[i]) begin
            checks++;
            if (obs_q[i].pc !== exp_q[i] || obs_q[i].instr !== img(exp_q[i])) begin
                failures++;
                $display("FAIL same_cycle_dec[%0d] got=%h/%h want=%h/%h", i, obs_q[i].pc, obs_q[i].instr, exp_q[i], img(exp_q[i]));
            end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] after[$];
        bit seen;
        seen = 1'b0;
        rdy_pct = 100; rsp_pct = 100; dec_ready = 1'b1;
        reset_dut();
        repeat (4) @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        @(negedge clk);
        redirect_valid = 1'b0;
        repeat (15) @(negedge clk);
        foreach (log_q[i]) begin
            if (log_q[i].kind == 2) seen = 1'b1;
            else if (seen && log_q[i].kind == 0) after.push_back(log_q[i].pc);
        end
        checks++;
        if (after.size() < 2) begin failures++; $display("FAIL wrap_req_count got=%0d want>=2", after.size()); end
        else begin
            checks++;
            if (after[0] !== 32'hFFFF_FFFC || after[1] !== 32'h0) begin
                failures++; $display("FAIL wrap_req got=%h,%h want=fffffffc,00000000", after[0], after[1]);
            end
        end
        get_obs(1); build_exp(1);
        foreach (obs_q[i]) begin
            checks++;
            if (obs_q[i].pc !== exp_q[i] || obs_q[i].instr !== img(exp_q[i])) begin
                failures++;
                $display("FAIL wrap_dec[%0d] got=%h/%h want=%h/%h", i, obs_q[i].pc, obs_q[i].instr, exp_q[i], img(exp_q[i]));
            end
        end
    endtask

    task automatic test_random_reset();
        logic pv, pr, prd, prst;
        logic [31:0] pa;
        int rst_cyc;
        rdy_pct = 60; rsp_pct = 50;
        reset_dut();
        pv = 1'b0; pr = 1'b0; prd = 1'b0; prst = 1'b0; pa = 32'h0; rst_cyc = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            #1;
            if (pv && !pr && !prd && !prst) begin
                checks++;
                if (imem_req_valid !== 1'b1 || imem_req_addr !== pa) begin
                    failures++; $display("FAIL rand_req_hold cyc=%0d got=%b/%h want=1/%h", i, imem_req_valid, imem_req_addr, pa);
                end
            end
            if (rst && rst_cyc > 0) begin
                checks++;
                if (imem_req_valid !== 1'b0 || dec_valid !== 1'b0) begin
                    failures++; $display("FAIL rand_in_reset got=%b/%b want=0/0", imem_req_valid, dec_valid);
                end
            end
            rst_cyc = rst ? rst_cyc + 1 : 0;
            rst = (i >= 200 && i < 204);
            dec_ready = $urandom_range(3) != 0;
            redirect_valid = !rst && $urandom_range(19) == 0;
            redirect_pc = $urandom;
            #1;
            if (i == 204) begin
                checks++;
                if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC) begin
                    failures++; $display("FAIL rand_restart got=%b/%h want=1/%h", imem_req_valid, imem_req_addr, RST_PC);
                end
            end
            pv = imem_req_valid; pr = imem_req_ready; pa = imem_req_addr; prd = redirect_valid; prst = rst;
        end
        @(negedge clk);
        redirect_valid = 1'b0;
        rsp_pct = 100; rdy_pct = 100; dec_ready = 1'b1;
        repeat (10) @(negedge clk);
        get_obs(1); build_exp(1);
        checks++;
        if (obs_q.size() < 30) begin failures++; $display("FAIL rand_dec_count got=%0d want>=30", obs_q.size()); end
        foreach (obs_q[i]) begin
            checks++;
            if (obs_q[i].pc !== exp_q[i] || obs_q[i].instr !== img(exp_q[i])) begin
                failures++;
                $display("FAIL rand_dec[%0d] got=%h/%h want=%h/%h", i, obs_q[i].pc, obs_q[i].instr, exp_q[i], img(exp_q[i]));
            end
        end
        get_obs(0); build_exp(0);
        foreach (obs_q[i]) begin
            checks++;
            if (obs_q[i].pc !== exp_q[i]) begin failures++; $display("FAIL rand_req[%0d] got=%h want=%h", i, obs_q[i].pc, exp_q[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_same_cycle();
        test_wrap();
        test_random_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
